// File: rtl/lsu_mem_access_pkg.sv
// Shared definitions for the load/store access unit: funct3 codes, strobe
// patterns, tracker entry layout and access-size helpers.
package lsu_mem_access_pkg;

    localparam logic [2:0] FNC_LB  = 3'b000;
    localparam logic [2:0] FNC_LH  = 3'b001;
    localparam logic [2:0] FNC_LW  = 3'b010;
    localparam logic [2:0] FNC_LBU = 3'b100;
    localparam logic [2:0] FNC_LHU = 3'b101;
    localparam logic [2:0] FNC_SB  = 3'b000;
    localparam logic [2:0] FNC_SH  = 3'b001;
    localparam logic [2:0] FNC_SW  = 3'b010;

    localparam logic [3:0] WSTRB_B = 4'b0001;
    localparam logic [3:0] WSTRB_H = 4'b0011;
    localparam logic [3:0] WSTRB_W = 4'b1111;

    localparam int FNC_W   = 3;
    localparam int OFF_W   = 2;
    localparam int RD_W    = 5;
    localparam int ENTRY_W = FNC_W + OFF_W + RD_W;

    typedef enum logic [1:0] {
        SIZE_B = 2'b00,
        SIZE_H = 2'b01,
        SIZE_W = 2'b10
    } size_e;

    typedef struct packed {
        logic [FNC_W-1:0] fnc;
        logic [OFF_W-1:0] offset;
        logic [RD_W-1:0]  rd;
    } ld_entry_t;

    // The low two funct3 bits encode the access size for loads and stores alike.
    function automatic size_e fnc_size(input logic [1:0] fncLow);
        case (fncLow)
            2'b00:   return SIZE_B;
            2'b01:   return SIZE_H;
            default: return SIZE_W;
        endcase
    endfunction

    function automatic logic is_misaligned(input size_e sz, input logic [1:0] off);
        case (sz)
            SIZE_H:  return off[0];
            SIZE_W:  return off != 2'b00;
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic [1:0] align_off(input size_e sz, input logic [1:0] off);
        case (sz)
            SIZE_H:  return {off[1], 1'b0};
            SIZE_W:  return 2'b00;
            default: return off;
        endcase
    endfunction

endpackage

// File: rtl/lsu_load_fifo.sv
// In-order tracker of outstanding loads: DEPTH-entry synchronous FIFO holding
// {funct3, offset, rd} for each load awaiting its memory response.
module lsu_load_fifo
    import lsu_mem_access_pkg::*;
#(
    parameter int DEPTH = 2,
    parameter int WIDTH = ENTRY_W,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = PTR_W + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty,
    output logic [CNT_W-1:0] count
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wrPtr_q;
    logic [PTR_W-1:0] rdPtr_q;
    logic [CNT_W-1:0] count_q;
    logic             doPush;
    logic             doPop;

    assign full   = (count_q == CNT_W'(DEPTH));
    assign empty  = (count_q == '0);
    assign count  = count_q;
    assign rdata  = mem_q[rdPtr_q];
    assign doPush = push & ~full;
    assign doPop  = pop & ~empty;

    // Pointers are exactly log2(DEPTH) bits so they wrap without extra logic.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wrPtr_q <= '0;
            rdPtr_q <= '0;
            count_q <= '0;
        end else begin
            if (doPush) wrPtr_q <= wrPtr_q + 1'b1;
            if (doPop)  rdPtr_q <= rdPtr_q + 1'b1;
            case ({doPush, doPop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (doPush) mem_q[wrPtr_q] <= wdata;
    end

endmodule

// File: rtl/lsu_mem_access.sv
// Load/store access unit feeding mem_read_decoder. Optional MISALIGN_TRAP_EN
// traps misaligned requests instead of force-aligning their byte offset.
module lsu_mem_access
    import lsu_mem_access_pkg::*;
#(
    parameter int DEPTH  = 2,
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [2:0]        req_fnc,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    input  logic [4:0]        req_rd,
    output logic              mem_valid,
    input  logic              mem_ready,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic [3:0]        mem_wstrb,
    input  logic              mem_rvalid,
    input  logic [31:0]       mem_rdata,
    output logic              ld_valid,
    output logic [2:0]        ld_fnc,
    output logic [1:0]        ld_offset,
    output logic [31:0]       ld_raw,
    output logic [4:0]        ld_rd,
    output logic              busy
`ifdef MISALIGN_TRAP_EN
    ,
    output logic              misalign
`endif
);

    localparam int CNT_W = $clog2(DEPTH) + 1;

    size_e             reqSize;
    logic [1:0]        reqOff;
    logic              accept;
    logic              issue;
    logic              push;
    logic              pop;
    logic              fifoFull;
    logic              fifoEmpty;
    logic [CNT_W-1:0]  cnt;
    ld_entry_t         pushEntry;
    ld_entry_t         headEntry;
    logic [3:0]        strobe;
    logic [31:0]       wdataRep;

    logic              memValid_q, memValid_d;
    logic [ADDR_W-1:0] memAddr_q,  memAddr_d;
    logic [31:0]       memWdata_q, memWdata_d;
    logic [3:0]        memWstrb_q, memWstrb_d;
    logic              ldValid_q;
    ld_entry_t         ldEntry_q;
    logic [31:0]       ldRaw_q;

    assign reqSize   = fnc_size(req_fnc[1:0]);
    assign reqOff    = align_off(reqSize, req_addr[1:0]);
    // Full is judged on the registered count; a same-cycle pop does not bypass it.
    assign req_ready = (~memValid_q | mem_ready) & ~fifoFull;
    assign accept    = req_valid & req_ready;
    assign push      = issue & ~req_we;
    assign pop       = mem_rvalid & ~fifoEmpty;
    assign pushEntry = '{fnc: req_fnc, offset: reqOff, rd: req_rd};

`ifdef MISALIGN_TRAP_EN
    logic reqMis;
    logic misalign_q;

    assign reqMis   = is_misaligned(reqSize, req_addr[1:0]);
    assign issue    = accept & ~reqMis;
    assign misalign = misalign_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) misalign_q <= 1'b0;
        else        misalign_q <= accept & reqMis;
    end
`else
    assign issue = accept;
`endif

    always_comb begin
        strobe   = WSTRB_W;
        wdataRep = req_wdata;
        case (reqSize)
            SIZE_B: begin
                strobe   = WSTRB_B << reqOff;
                wdataRep = {4{req_wdata[7:0]}};
            end
            SIZE_H: begin
                strobe   = WSTRB_H << reqOff;
                wdataRep = {2{req_wdata[15:0]}};
            end
            default: ;
        endcase
        if (!req_we) strobe = 4'b0000;
    end

    // Request fields are held while the memory stalls; a new issue only happens
    // once the previous request has handshaken, so it can simply overwrite them.
    always_comb begin
        memValid_d = memValid_q;
        memAddr_d  = memAddr_q;
        memWdata_d = memWdata_q;
        memWstrb_d = memWstrb_q;
        if (issue) begin
            memValid_d = 1'b1;
            memAddr_d  = {req_addr[ADDR_W-1:2], 2'b00};
            memWdata_d = wdataRep;
            memWstrb_d = strobe;
        end else if (mem_ready) begin
            memValid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            memValid_q <= 1'b0;
            memAddr_q  <= '0;
            memWdata_q <= '0;
            memWstrb_q <= '0;
        end else begin
            memValid_q <= memValid_d;
            memAddr_q  <= memAddr_d;
            memWdata_q <= memWdata_d;
            memWstrb_q <= memWstrb_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ldValid_q <= 1'b0;
            ldEntry_q <= '0;
            ldRaw_q   <= '0;
        end else begin
            ldValid_q <= pop;
            if (pop) begin
                ldEntry_q <= headEntry;
                ldRaw_q   <= mem_rdata;
            end
        end
    end

    lsu_load_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (ENTRY_W)
    ) uLoadFifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push),
        .pop   (pop),
        .wdata (pushEntry),
        .rdata (headEntry),
        .full  (fifoFull),
        .empty (fifoEmpty),
        .count (cnt)
    );

    assign mem_valid = memValid_q;
    assign mem_addr  = memAddr_q;
    assign mem_wdata = memWdata_q;
    assign mem_wstrb = memWstrb_q;
    assign ld_valid  = ldValid_q;
    assign ld_fnc    = ldEntry_q.fnc;
    assign ld_offset = ldEntry_q.offset;
    assign ld_rd     = ldEntry_q.rd;
    assign ld_raw    = ldRaw_q;
    assign busy      = memValid_q | (cnt != '0);

endmodule

// File: tb/tb_lsu_mem_access.sv
// Scoreboard bench for lsu_mem_access: directed test-plan sequences followed by
// randomized traffic, checked against a transaction-level model of the unit.
module tb_lsu_mem_access;

    localparam int DEPTH  = 2;
    localparam int ADDR_W = 32;
`ifdef MISALIGN_TRAP_EN
    localparam bit TRAP = 1'b1;
`else
    localparam bit TRAP = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              req_valid = 1'b0;
    logic              req_ready;
    logic              req_we = 1'b0;
    logic [2:0]        req_fnc = '0;
    logic [ADDR_W-1:0] req_addr = '0;
    logic [31:0]       req_wdata = '0;
    logic [4:0]        req_rd = '0;
    logic              mem_valid;
    logic              mem_ready = 1'b0;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic [3:0]        mem_wstrb;
    logic              mem_rvalid = 1'b0;
    logic [31:0]       mem_rdata = '0;
    logic              ld_valid;
    logic [2:0]        ld_fnc;
    logic [1:0]        ld_offset;
    logic [31:0]       ld_raw;
    logic [4:0]        ld_rd;
    logic              busy;
`ifdef MISALIGN_TRAP_EN
    logic              misalign;
`endif

    always #5 clk = ~clk;

    lsu_mem_access #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_fnc(req_fnc), .req_addr(req_addr), .req_wdata(req_wdata), .req_rd(req_rd),
        .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb),
        .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
        .ld_valid(ld_valid), .ld_fnc(ld_fnc), .ld_offset(ld_offset),
        .ld_raw(ld_raw), .ld_rd(ld_rd), .busy(busy)
`ifdef MISALIGN_TRAP_EN
        , .misalign(misalign)
`endif
    );

    typedef struct { logic [31:0] addr; logic [3:0] strb; logic [31:0] data; bit isStore; } memTxn_t;
    typedef struct { logic [2:0] fnc; logic [1:0] off; logic [4:0] rd; } ldTag_t;
    typedef struct { logic [31:0] raw; ldTag_t tag; int stamp; } ldTxn_t;

    memTxn_t memQ[$];
    ldTag_t  tagQ[$];
    ldTxn_t  ldQ[$];

    int checks = 0;
    int passes = 0;
    int cyc = 0;
    bit monEn = 1'b0;

    // Model state: memory request in flight, loads accepted, loads seen by memory.
    bit mvM = 1'b0;
    bit mIsLoad = 1'b0;
    int cntM = 0;
    int memPendLoads = 0;
    bit expReady = 1'b1;
    bit expBusy = 1'b0;
    bit expMv = 1'b0;
    int lastMisCyc = -10;
    logic [31:0] lastRaw = '0;
    ldTag_t lastTag = '{3'b0, 2'b0, 5'b0};

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    function automatic int nBytes(input logic [2:0] fnc);
        case (fnc[1:0])
            2'b00:   return 1;
            2'b01:   return 2;
            default: return 4;
        endcase
    endfunction

    function automatic bit isMis(input logic [2:0] fnc, input logic [31:0] addr);
        int o = int'(addr[1:0]);
        return (o % nBytes(fnc)) != 0;
    endfunction

    function automatic logic [1:0] effOff(input logic [2:0] fnc, input logic [31:0] addr);
        int o = int'(addr[1:0]);
        return 2'(o - (o % nBytes(fnc)));
    endfunction

    function automatic logic [3:0] expStrb(input logic [2:0] fnc, input logic [31:0] addr);
        int n = nBytes(fnc);
        return 4'(((1 << n) - 1) << effOff(fnc, addr));
    endfunction

    function automatic logic [31:0] expData(input logic [2:0] fnc, input logic [31:0] w);
        logic [31:0] r;
        int n = nBytes(fnc);
        for (int i = 0; i < 4; i++) r[8*i +: 8] = w[8*(i % n) +: 8];
        return r;
    endfunction

    // One clock cycle of stimulus; the model predicts what the DUT must show.
    task automatic applyStimulus(input bit v, input bit we, input logic [2:0] fnc,
                                 input logic [31:0] addr, input logic [31:0] wdata,
                                 input logic [4:0] rd, input bit mr, input bit rv,
                                 input logic [31:0] rdat);
        bit acc, mis, iss, hs, pop;
        ldTag_t tag;
        @(posedge clk);
        #1;
        cyc++;
        req_valid = v; req_we = we; req_fnc = fnc; req_addr = addr;
        req_wdata = wdata; req_rd = rd; mem_ready = mr; mem_rvalid = rv; mem_rdata = rdat;
        expMv    = mvM;
        expBusy  = mvM || (cntM > 0);
        expReady = (!mvM || mr) && (cntM < DEPTH);
        acc = v && expReady;
        mis = acc && TRAP && isMis(fnc, addr);
        iss = acc && !mis;
        hs  = mvM && mr;
        pop = rv && (cntM > 0);
        if (mis) lastMisCyc = cyc;
        if (iss) begin
            memQ.push_back('{addr & ~32'h3, we ? expStrb(fnc, addr) : 4'h0, expData(fnc, wdata), we});
            if (!we) tagQ.push_back('{fnc, effOff(fnc, addr), rd});
        end
        if (pop) begin
            tag = tagQ.pop_front();
            ldQ.push_back('{rdat, tag, cyc});
        end
        memPendLoads += int'(hs && mIsLoad) - int'(pop);
        cntM += int'(iss && !we) - int'(pop);
        if (iss) begin
            mvM = 1'b1;
            mIsLoad = !we;
        end else if (hs) begin
            mvM = 1'b0;
        end
    endtask

    task automatic idle(input bit mr, input bit rv, input logic [31:0] rdat);
        applyStimulus(1'b0, 1'b0, 3'b000, 32'h0, 32'h0, 5'd0, mr, rv, rdat);
    endtask

    task automatic resetDut();
        @(posedge clk);
        #1;
        monEn = 1'b0;
        rst_n = 1'b0;
        req_valid = 1'b0; mem_ready = 1'b0; mem_rvalid = 1'b0;
        memQ.delete(); tagQ.delete(); ldQ.delete();
        mvM = 1'b0; mIsLoad = 1'b0; cntM = 0; memPendLoads = 0;
        expReady = 1'b1; expBusy = 1'b0; expMv = 1'b0; lastMisCyc = -10;
        lastRaw = '0; lastTag = '{3'b0, 2'b0, 5'b0};
        #1;
        checkOutput("rst_mem_valid", mem_valid, 0);
        checkOutput("rst_mem_addr", mem_addr, 0);
        checkOutput("rst_mem_wdata", mem_wdata, 0);
        checkOutput("rst_mem_wstrb", mem_wstrb, 0);
        checkOutput("rst_ld", {ld_valid, ld_fnc, ld_offset, ld_raw, ld_rd}, 0);
        checkOutput("rst_busy", busy, 0);
        checkOutput("rst_req_ready", req_ready, 1);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        monEn = 1'b1;
    endtask

    // Monitor: mid-cycle, compare what the DUT presents with the scoreboard.
    always @(negedge clk) begin
        if (monEn && rst_n) begin
            bit expLd;
            ldTxn_t l;
            checkOutput("req_ready", req_ready, expReady);
            checkOutput("busy", busy, expBusy);
            checkOutput("mem_valid", mem_valid, expMv);
            if (mem_valid) begin
                if (memQ.size() == 0) begin
                    checkOutput("mem_valid_no_txn", mem_valid, 0);
                end else begin
                    checkOutput("mem_addr", mem_addr, memQ[0].addr);
                    checkOutput("mem_wstrb", mem_wstrb, memQ[0].strb);
                    if (memQ[0].isStore) checkOutput("mem_wdata", mem_wdata, memQ[0].data);
                    if (mem_ready) void'(memQ.pop_front());
                end
            end
            expLd = (ldQ.size() > 0) && (ldQ[0].stamp == cyc - 1);
            checkOutput("ld_valid", ld_valid, expLd);
            if (expLd) begin
                l = ldQ.pop_front();
                lastRaw = l.raw;
                lastTag = l.tag;
            end
            checkOutput("ld_fields", {ld_raw, ld_fnc, ld_offset, ld_rd},
                        {lastRaw, lastTag.fnc, lastTag.off, lastTag.rd});
`ifdef MISALIGN_TRAP_EN
            checkOutput("misalign", misalign, lastMisCyc == cyc - 1);
`endif
        end
    end

    function automatic logic [2:0] randFnc(input bit we);
        int k;
        if (we) begin
            k = $urandom_range(0, 2);
            return 3'(k);
        end
        k = $urandom_range(0, 4);
        case (k)
            0: return 3'b000;
            1: return 3'b001;
            2: return 3'b010;
            3: return 3'b100;
            default: return 3'b101;
        endcase
    endfunction

    initial begin
        bit v, we, mr, rv;
        logic [2:0] fnc;
        resetDut();

        // Byte store at the top lane of a word.
        applyStimulus(1, 1, 3'b000, 32'h1003, 32'h0000_00A5, 5'd0, 1, 0, 0);
        idle(1, 0, 0);
        idle(1, 0, 0);

        // Halfword load with a response two cycles after acceptance.
        applyStimulus(1, 0, 3'b001, 32'h2002, 32'h0, 5'd7, 1, 0, 0);
        idle(1, 0, 0);
        idle(1, 1, 32'h8001_1234);
        idle(1, 0, 0);
        idle(1, 0, 0);

        // Three loads back to back: the tracker fills, then drains in order.
        applyStimulus(1, 0, 3'b010, 32'h500, 32'h0, 5'd1, 1, 0, 0);
        applyStimulus(1, 0, 3'b100, 32'h601, 32'h0, 5'd2, 1, 0, 0);
        applyStimulus(1, 0, 3'b000, 32'h702, 32'h0, 5'd3, 1, 0, 0);
        applyStimulus(1, 0, 3'b000, 32'h702, 32'h0, 5'd3, 1, 0, 0);
        applyStimulus(1, 0, 3'b000, 32'h702, 32'h0, 5'd3, 1, 1, 32'h1111_1111);
        applyStimulus(1, 0, 3'b000, 32'h702, 32'h0, 5'd3, 1, 1, 32'h2222_2222);
        idle(1, 0, 0);
        idle(1, 1, 32'h3333_3333);
        idle(1, 0, 0);

        // Word store stalled by memory for five cycles.
        applyStimulus(1, 1, 3'b010, 32'h3000, 32'hDEAD_BEEF, 5'd0, 0, 0, 0);
        repeat (5) applyStimulus(1, 1, 3'b000, 32'h3100, 32'h55, 5'd0, 0, 0, 0);
        idle(1, 0, 0);
        idle(1, 0, 0);

        // Reset with two loads outstanding; later responses must be ignored.
        applyStimulus(1, 0, 3'b010, 32'h800, 32'h0, 5'd4, 1, 0, 0);
        applyStimulus(1, 0, 3'b010, 32'h804, 32'h0, 5'd5, 1, 0, 0);
        idle(1, 0, 0);
        resetDut();
        idle(1, 1, 32'hAAAA_AAAA);
        idle(1, 0, 0);
        idle(1, 1, 32'hBBBB_BBBB);
        idle(1, 0, 0);

        // Misaligned halfword store.
        applyStimulus(1, 1, 3'b001, 32'h4001, 32'h0000_BEEF, 5'd0, 1, 0, 0);
        idle(1, 0, 0);
        idle(1, 0, 0);

        for (int i = 0; i < 3000; i++) begin
            v   = $urandom_range(0, 99) < 60;
            we  = $urandom_range(0, 1) == 1;
            fnc = randFnc(we);
            mr  = $urandom_range(0, 99) < 70;
            if (memPendLoads > 0) rv = $urandom_range(0, 99) < 50;
            else                  rv = (cntM == 0) && ($urandom_range(0, 99) < 10);
            applyStimulus(v, we, fnc, $urandom, $urandom, 5'($urandom_range(0, 31)), mr, rv, $urandom);
        end
        repeat (4) idle(1, 0, 0);

        @(posedge clk);
        #1;
        monEn = 1'b0;
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/lsu_mem_access.md
Name: lsu_mem_access

Overview:
Load/store access unit sitting directly upstream of the load data decoder (mem_read_decoder). It accepts load/store requests from the pipeline with a valid/ready handshake, drives a word-aligned data-memory port with byte strobes and replicated store data, and tracks up to DEPTH outstanding loads. On each in-order memory response it presents raw word, funct3 and byte offset to the decoder.

Parameters:
DEPTH, 2, max outstanding loads (tracker FIFO entries, power of 2, >=2)
ADDR_W, 32, byte address width

Ports:
clk  in  1  clock, all state on rising edge
rst_n  in  1  asynchronous, active-low reset
req_valid  in  1  pipeline request valid
req_ready  out  1  unit can accept a request this cycle
req_we  in  1  1=store, 0=load
req_fnc  in  3  funct3 (FNC_LB/LH/LW/LBU/LHU, FNC_SB/SH/SW)
req_addr  in  ADDR_W  byte address
req_wdata  in  32  store data, LSB-justified
req_rd  in  5  load destination register
mem_valid  out  1  memory request valid
mem_ready  in  1  memory accepts request
mem_addr  out  ADDR_W  word address (bits [1:0] = 0)
mem_wdata  out  32  lane-replicated store data
mem_wstrb  out  4  byte write strobes, 0 for loads
mem_rvalid  in  1  load response valid, in order, no backpressure
mem_rdata  in  32  load response word
ld_valid  out  1  one-cycle pulse, decoder inputs valid
ld_fnc  out  3  funct3 of completing load
ld_offset  out  2  byte offset (addr[1:0]) of completing load
ld_raw  out  32  registered mem_rdata
ld_rd  out  5  destination of completing load
busy  out  1  mem_valid or any load outstanding

Behaviour:
- Reset: mem_valid, mem_addr, mem_wdata, mem_wstrb, ld_valid, ld_fnc, ld_offset, ld_raw, ld_rd all 0. FIFO and counter empty. Responses arriving after reset are ignored.
- req_ready = (!mem_valid | mem_ready) & (cnt < DEPTH). It does not depend on req_* inputs. cnt = loads accepted but not yet responded.
- Accept on req_valid & req_ready. The memory request is registered, so mem_valid rises the cycle after acceptance. mem_addr/wdata/wstrb are held stable while mem_valid & !mem_ready.
- Loads: cnt is incremented and {fnc, offset, rd} pushed at acceptance. The request is not pushed at the memory handshake. mem_wstrb = 0.
- Store strobes: SB = 4'b0001 << off; SH = 4'b0011 << off; SW = 4'b1111.
- Store data: SB = {4{wdata[7:0]}}; SH = {2{wdata[15:0]}}; SW = wdata.
- Response: mem_rvalid with FIFO non-empty pops the head. Next cycle ld_valid = 1 with ld_raw = mem_rdata and ld_fnc/offset/rd from the head (1-cycle latency). Otherwise ld_valid = 0 and ld_* hold their last values.
- mem_rvalid with FIFO empty is ignored; no state change.
- Same-cycle accept-load and pop: cnt unchanged, FIFO push and pop both occur.
- Full (cnt == DEPTH): req_ready = 0 even if a pop occurs that cycle. There is no combinational bypass.
- FIFO pointers are log2(DEPTH) bits wide and wrap naturally.
- Misaligned: halfword with off[0] = 1, or word with off != 0.

Optional Feature:
MISALIGN_TRAP_EN
- Defined: adds output misalign (1 bit, reset 0). A misaligned accepted request pulses misalign for one cycle after acceptance. It is not issued to memory, not pushed to the FIFO, and cnt is unchanged.
- Undefined: no port. The offset is force-aligned before use (halfword clears off[0], word clears off[1:0]), for both strobes and ld_offset.

Decomposition:
- FNC_* constants come from the shared Opcode.vh.
- New header lsu_defs.vh holds the strobe constants (WSTRB_B/H/W) and the FIFO entry field widths.
- One sub-module: lsu_load_fifo. It is a DEPTH-entry, 10-bit-wide sync FIFO with push/pop/full/empty/count and asynchronous active-low reset.

Test Plan:
- SB addr 0x1003, wdata 0x000000A5, mem_ready = 1 -> mem_addr 0x1000, wstrb 4'b1000, wdata 0xA5A5A5A5, no FIFO push.
- LH addr 0x2002 rd 7, mem_rdata 0x8001_1234 two cycles later -> ld_valid pulse, ld_raw 0x80011234, ld_fnc 001, ld_offset 2, ld_rd 7.
- Three back-to-back loads, DEPTH = 2, no responses -> req_ready low after the 2nd accept; first response restores req_ready the following cycle; responses return rd in issue order.
- mem_ready held 0 for 5 cycles on SW 0x3000 -> mem_* stable; req_ready = 0 throughout; released on the handshake.
- rst_n asserted with 2 loads outstanding, then 2 mem_rvalid pulses -> no ld_valid, cnt = 0, all outputs 0.
- SH addr 0x4001: with MISALIGN_TRAP_EN -> misalign pulse and mem_valid stays 0; without -> wstrb 4'b0011, mem_addr 0x4000.
